// File: rtl/counter_bus_slave_pkg.sv
// Shared constants and types for the counter bus slave.
package counter_bus_pkg;

  typedef logic [31:0] word_t;

  // Register index (low two word-address bits)
  localparam logic [1:0] ADDR_COUNTER = 2'd0;
  localparam logic [1:0] ADDR_CONFIG  = 2'd1;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;
  localparam logic [1:0] ADDR_IRQ     = 2'd3;

  // Bit positions inside CONFIG / STATUS / IRQ
  localparam int CFG_EN_BIT     = 0;
  localparam int CFG_DIR_BIT    = 1;
  localparam int CFG_IRE_BIT    = 2;
  localparam int STS_LT1000_BIT = 0;
  localparam int IRQ_PEND_BIT   = 0;

  // Byte-merge of new data over old data under a byte-enable mask.
  function automatic word_t byte_merge(input word_t new_w, input word_t old_w,
                                       input logic [3:0] be);
    word_t r;
    for (int b = 0; b < 4; b++)
      r[b*8 +: 8] = be[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
    return r;
  endfunction

endpackage

// File: rtl/counter_bus_slave_if.sv
// Word-addressed memory-mapped bus between a master and the counter slave.
interface counter_bus_slave_if #(
  parameter int ADDR_WIDTH = 4
);
  import counter_bus_pkg::*;

  logic [ADDR_WIDTH-1:0] address;
  logic                  read;
  logic                  write;
  word_t                 writeData;
  logic [3:0]            byteEnable;
  word_t                 readData;
  logic                  readDataValid;

  modport master (
    output address, read, write, writeData, byteEnable,
    input  readData, readDataValid
  );

  modport slave (
    input  address, read, write, writeData, byteEnable,
    output readData, readDataValid
  );
endinterface

// File: rtl/counter_bus_slave_irq_latch.sv
// Sticky interrupt-pending bit: a set pulse beats a same-cycle W1C clear.
module counter_irq_latch (
  input  logic clk,
  input  logic reset,
  input  logic set_i,
  input  logic clr_i,
  output logic pend_o
);

  logic pend_q, pend_d;

  // Next state: set has priority over clear
  always_comb begin
    pend_d = pend_q;
    if (clr_i) pend_d = 1'b0;
    if (set_i) pend_d = 1'b1;
  end

  // Pending register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) pend_q <= 1'b0;
    else       pend_q <= pend_d;
  end

  assign pend_o = pend_q;

endmodule

// File: rtl/counter_bus_slave.sv
// Bus slave in front of the counter core: decodes accesses into core strobes,
// returns register values with one cycle of read latency, and turns the core
// interrupt pulse into a sticky W1C pending bit / level irq.
module counter_bus_slave
  import counter_bus_pkg::*;
#(
  parameter int    ADDR_WIDTH          = 4,
  parameter word_t UNMAPPED_READ_VALUE = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  counter_bus_slave_if.slave   bus,
  output word_t                counterIn,
  output logic                 counterEnIn,
  output logic                 counterDirIn,
  output logic                 counterIreIn,
  output logic                 counterWe,
  output logic                 counterRe,
  output logic                 counterConfigWe,
  output logic                 counterConfigRe,
  output logic                 counterStatusRe,
  input  word_t                counterOut,
  input  logic                 counterEnOut,
  input  logic                 counterDirOut,
  input  logic                 counterIreOut,
  input  logic                 counterLT1000Out,
  input  logic                 counterIrqOut,
  output logic                 irq
);

  // Decode: only the low four word addresses are mapped.
  logic [ADDR_WIDTH-1:0] addr_hi;
  logic                  mapped;
  logic [1:0]            reg_idx;
  logic                  wr_acc, rd_acc;

  assign addr_hi = bus.address >> 2;
  assign mapped  = (addr_hi == '0);
  assign reg_idx = bus.address[1:0];

  // A write wins over a simultaneous read; nothing is accepted during reset.
  assign wr_acc = bus.write & ~reset;
  assign rd_acc = bus.read & ~bus.write & ~reset;

  logic  irq_pend;
  logic  irq_clr;
  word_t rdata;

  word_t readData_q, readData_d;
  logic  readDataValid_q, readDataValid_d;

  // Core strobes and load values; idle outputs mirror the core's state
  always_comb begin
    counterIn       = counterOut;
    counterEnIn     = counterEnOut;
    counterDirIn    = counterDirOut;
    counterIreIn    = counterIreOut;
    counterWe       = 1'b0;
    counterRe       = 1'b0;
    counterConfigWe = 1'b0;
    counterConfigRe = 1'b0;
    counterStatusRe = 1'b0;
    irq_clr         = 1'b0;
    if (wr_acc && mapped) begin
      unique case (reg_idx)
        ADDR_COUNTER: begin
          counterIn = byte_merge(bus.writeData, counterOut, bus.byteEnable);
          counterWe = (bus.byteEnable != 4'b0000);
        end
        ADDR_CONFIG: begin
          if (bus.byteEnable[0]) begin
            counterConfigWe = 1'b1;
            counterEnIn     = bus.writeData[CFG_EN_BIT];
            counterDirIn    = bus.writeData[CFG_DIR_BIT];
            counterIreIn    = bus.writeData[CFG_IRE_BIT];
          end
        end
        ADDR_STATUS: ;
        ADDR_IRQ:
          irq_clr = bus.byteEnable[0] & bus.writeData[IRQ_PEND_BIT];
      endcase
    end
    if (rd_acc && mapped) begin
      unique case (reg_idx)
        ADDR_COUNTER: counterRe       = 1'b1;
        ADDR_CONFIG:  counterConfigRe = 1'b1;
        ADDR_STATUS:  counterStatusRe = 1'b1;
        ADDR_IRQ:     ;
      endcase
    end
  end

  // Read mux; IRQ reads see the pending bit before this cycle's set
  always_comb begin
    rdata = '0;
    if (!mapped) rdata = UNMAPPED_READ_VALUE;
    else begin
      unique case (reg_idx)
        ADDR_COUNTER: rdata = counterOut;
        ADDR_CONFIG: begin
          rdata[CFG_EN_BIT]  = counterEnOut;
          rdata[CFG_DIR_BIT] = counterDirOut;
          rdata[CFG_IRE_BIT] = counterIreOut;
        end
        ADDR_STATUS:  rdata[STS_LT1000_BIT] = counterLT1000Out;
        ADDR_IRQ:     rdata[IRQ_PEND_BIT]   = irq_pend;
      endcase
    end
  end

  // Read data holds between accesses; valid follows the accept by one cycle
  always_comb begin
    readData_d      = readData_q;
    readDataValid_d = rd_acc;
    if (rd_acc) readData_d = rdata;
  end

  // Read response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      readData_q      <= '0;
      readDataValid_q <= 1'b0;
    end else begin
      readData_q      <= readData_d;
      readDataValid_q <= readDataValid_d;
    end
  end

  assign bus.readData      = readData_q;
  assign bus.readDataValid = readDataValid_q;

  counter_irq_latch u_irq (
    .clk    (clk),
    .reset  (reset),
    .set_i  (counterIrqOut),
    .clr_i  (irq_clr),
    .pend_o (irq_pend)
  );

  assign irq = irq_pend;

endmodule
